// File: rtl/qos_pkg.sv
// qos_pkg: shared types and constants for the QoS virtual-channel buffer.
//   state_e          one-hot controller state encoding
//   DEF_LOW          almost-empty threshold loaded at reset
//   DEF_HIGH_MARGIN  almost-full threshold at reset is DEPTH minus this margin
package qos_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

    localparam int unsigned DEF_LOW         = 1;
    localparam int unsigned DEF_HIGH_MARGIN = 1;

endpackage

// File: rtl/qos_fifo_sync.sv
// qos_fifo_sync: single-clock FIFO with registered read data and occupancy.
//   clk, reset   rising-edge clock, synchronous active-low reset
//   wr_en_i      write wr_data_i (caller guarantees space or a same-cycle read)
//   rd_en_i      read one word (caller guarantees the FIFO is not empty)
//   rd_data_o    word read at the previous edge; holds when no read happens
//   rd_valid_o   one-cycle pulse accompanying rd_data_o
//   count_o      occupancy, 0..DEPTH
module qos_fifo_sync #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [AW:0]       count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
    end

    // NOTE: all state uses non-blocking assignment so a write and read of the same slot in one cycle reads the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (wr_en_i) wptr_q <= wptr_q + 1'b1;
            if (rd_en_i) begin
                rptr_q    <= rptr_q + 1'b1;
                rd_data_q <= mem_q[rptr_q];
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;

endmodule

// File: rtl/qos_vc_param.sv
// qos_vc_param: QoS virtual-channel buffer. Incoming words are steered by their
// top VC_W bits into one of NUM_VC FIFOs, each drained by its own pop.
//   clk, reset                  clock, synchronous active-low reset
//   init, umbral_high/low       configuration request and thresholds (captured in INIT)
//   push, data_in               write into FIFO[class]
//   pop                         per-VC pop; fifo_dataout/fifo_valid one cycle later
//   almost_full/almost_empty/fifo_empty, pause, drop   status flags
//   req, idx, clr_on_read       statistics read; valid/data one cycle later
//   active_out, idle_out, error_out                    controller state
module qos_vc_param
    import qos_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    localparam int VC_W  = $clog2(NUM_VC),
    localparam int AW    = $clog2(DEPTH),
    localparam int IDX_W = $clog2(NUM_VC + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [AW:0]              umbral_high,
    input  logic [AW:0]              umbral_low,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_VC-1:0]        pop,
    output logic [NUM_VC*DATA_W-1:0] fifo_dataout,
    output logic [NUM_VC-1:0]        fifo_valid,
    output logic [NUM_VC-1:0]        almost_full,
    output logic [NUM_VC-1:0]        almost_empty,
    output logic [NUM_VC-1:0]        fifo_empty,
    output logic                     pause,
    output logic                     drop,
    input  logic                     req,
    input  logic [IDX_W-1:0]         idx,
    input  logic                     clr_on_read,
    output logic                     valid,
    output logic [CNT_W-1:0]         data,
    output logic                     active_out,
    output logic                     idle_out,
    output logic                     error_out
);

    localparam logic [AW:0]      DEF_HIGH = (AW+1)'(DEPTH - DEF_HIGH_MARGIN);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [IDX_W-1:0] DROP_IDX = IDX_W'(NUM_VC);

    state_e              state_q, state_d;
    logic [AW:0]         high_q, low_q;
    logic [AW:0]         cnt [NUM_VC];
    logic [VC_W-1:0]     cls;
    logic                push_ok, pop_ok;
    logic [NUM_VC-1:0]   wr_en, rd_en, drop_vec, clr_fwd;
    logic                drop_d, drop_q;
    logic                clr_drop;
    logic [CNT_W-1:0]    fwd_q [NUM_VC];
    logic [CNT_W-1:0]    drop_cnt_q;
    logic [CNT_W-1:0]    rd_val;
    logic                valid_q;
    logic [CNT_W-1:0]    data_q;

    assign cls     = data_in[DATA_W-1 -: VC_W];
    assign push_ok = push && (state_q == ST_IDLE || state_q == ST_ACTIVE);
    assign pop_ok  = (state_q == ST_IDLE || state_q == ST_ACTIVE || state_q == ST_ERROR);

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        logic sel, full;
        assign sel         = push_ok && (cls == VC_W'(i));
        assign full        = (cnt[i] == FULL_CNT);
        assign rd_en[i]    = pop[i] && pop_ok && !fifo_empty[i];
        // A full FIFO still takes the word when it is popped in the same cycle.
        assign wr_en[i]    = sel && (!full || rd_en[i]);
        assign drop_vec[i] = sel && full && !rd_en[i];
        assign clr_fwd[i]  = req && clr_on_read && (idx == IDX_W'(i));

        qos_fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (wr_en[i]),
            .wr_data_i  (data_in),
            .rd_en_i    (rd_en[i]),
            .rd_data_o  (fifo_dataout[i*DATA_W +: DATA_W]),
            .rd_valid_o (fifo_valid[i]),
            .count_o    (cnt[i])
        );

        assign almost_full[i]  = (cnt[i] >= high_q);
        assign almost_empty[i] = (cnt[i] <= low_q);
        assign fifo_empty[i]   = (cnt[i] == '0);
    end

    assign drop_d   = |drop_vec;
    assign clr_drop = req && clr_on_read && (idx == DROP_IDX);

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (drop_d)      state_d = ST_ERROR;
                else if (init)   state_d = ST_INIT;
                else if (|wr_en) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (drop_d)                    state_d = ST_ERROR;
                else if (&fifo_empty && !push) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    // Counter read mux; indices above NUM_VC read as zero.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (idx == IDX_W'(k)) rd_val = fwd_q[k];
        end
        if (idx == DROP_IDX) rd_val = drop_cnt_q;
    end

    // Clear-on-read wins over the old value; an increment in the same cycle lands on top of zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != '1)) base = base + 1'b1;
        return base;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            high_q     <= DEF_HIGH;
            low_q      <= (AW+1)'(DEF_LOW);
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            for (int k = 0; k < NUM_VC; k++) fwd_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                high_q <= umbral_high;
                low_q  <= umbral_low;
            end
            drop_q     <= drop_d;
            drop_cnt_q <= cnt_next(drop_cnt_q, drop_d, clr_drop);
            for (int k = 0; k < NUM_VC; k++) fwd_q[k] <= cnt_next(fwd_q[k], rd_en[k], clr_fwd[k]);
            valid_q <= req;
            if (req) data_q <= rd_val;
        end
    end

    assign pause      = |almost_full;
    assign drop       = drop_q;
    assign valid      = valid_q;
    assign data       = data_q;
    assign idle_out   = (state_q == ST_IDLE);
    assign active_out = (state_q == ST_ACTIVE);
    assign error_out  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_qos_vc_param.sv
// tb_qos_vc_param: directed self-checking bench for qos_vc_param
// (DATA_W=12, NUM_VC=4, DEPTH=8, CNT_W=8).
module tb_qos_vc_param;

    localparam int DATA_W = 12;
    localparam int NUM_VC = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int AW     = 3;
    localparam int IDX_W  = 3;

    logic                     clk = 1'b0;
    logic                     reset, init, push, req, clr_on_read;
    logic [AW:0]              umbral_high, umbral_low;
    logic [DATA_W-1:0]        data_in;
    logic [NUM_VC-1:0]        pop;
    logic [IDX_W-1:0]         idx;
    logic [NUM_VC*DATA_W-1:0] fifo_dataout;
    logic [NUM_VC-1:0]        fifo_valid, almost_full, almost_empty, fifo_empty;
    logic                     pause, drop, valid, active_out, idle_out, error_out;
    logic [CNT_W-1:0]         data;

    int n_tests = 0;
    int n_fail  = 0;

    qos_vc_param #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_high(umbral_high), .umbral_low(umbral_low),
        .push(push), .data_in(data_in), .pop(pop), .fifo_dataout(fifo_dataout),
        .fifo_valid(fifo_valid), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_empty(fifo_empty), .pause(pause), .drop(drop), .req(req), .idx(idx),
        .clr_on_read(clr_on_read), .valid(valid), .data(data), .active_out(active_out),
        .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init = 1'b0; push = 1'b0; pop = '0; req = 1'b0; clr_on_read = 1'b0; idx = '0; data_in = '0;
    endtask

    task automatic do_reset_init(input logic [AW:0] hi, input logic [AW:0] lo);
        idle_inputs();
        reset = 1'b0; umbral_high = hi; umbral_low = lo;
        tick(); tick();
        reset = 1'b1;
        tick();                 // RESET -> INIT
        init = 1'b1;
        tick(); tick();
        init = 1'b0;
        tick();                 // INIT -> IDLE
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        push = 1'b1; data_in = w;
        tick();
        push = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] dout(input int v);
        return fifo_dataout[v*DATA_W +: DATA_W];
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0; umbral_high = 4'd6; umbral_low = 4'd2;
        tick(); tick();
        n_tests++; if (fifo_empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty: got %h want f", fifo_empty); end
        n_tests++; if (almost_empty !== 4'hF) begin n_fail++; $display("FAIL reset_aempty: got %h want f", almost_empty); end
        n_tests++; if ({almost_full, fifo_valid, pause, drop, valid} !== 11'd0) begin
            n_fail++; $display("FAIL reset_flags: af=%h fv=%h pause=%b drop=%b valid=%b want 0", almost_full, fifo_valid, pause, drop, valid); end
        n_tests++; if (fifo_dataout !== '0 || data !== '0) begin
            n_fail++; $display("FAIL reset_data: dout=%h data=%h want 0", fifo_dataout, data); end
        n_tests++; if ({idle_out, active_out, error_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_state: got %b want 000", {idle_out, active_out, error_out}); end
        reset = 1'b1;
        tick();
        init = 1'b1; tick(); tick();
        init = 1'b0; tick();
        n_tests++; if ({idle_out, active_out, error_out} !== 3'b100) begin
            n_fail++; $display("FAIL init_idle: got %b want 100", {idle_out, active_out, error_out}); end
        n_tests++; if (almost_empty !== 4'hF || pause !== 1'b0) begin
            n_fail++; $display("FAIL init_flags: aempty=%h pause=%b want f/0", almost_empty, pause); end
    endtask

    task automatic test_classify();
        push_word(12'hC01); push_word(12'h402); push_word(12'h003); push_word(12'h804);
        n_tests++; if (fifo_empty !== 4'h0) begin n_fail++; $display("FAIL classify_empty: got %h want 0", fifo_empty); end
        n_tests++; if ({idle_out, active_out} !== 2'b01) begin
            n_fail++; $display("FAIL classify_active: got %b want 01", {idle_out, active_out}); end
        pop = 4'b1000; tick(); pop = '0;
        n_tests++; if (fifo_valid !== 4'b1000 || dout(3) !== 12'hC01) begin
            n_fail++; $display("FAIL pop_vc3: valid=%b data=%h want 1000/c01", fifo_valid, dout(3)); end
        tick();
        n_tests++; if (fifo_valid !== 4'b0000 || dout(3) !== 12'hC01) begin
            n_fail++; $display("FAIL pop_hold: valid=%b data=%h want 0000/c01", fifo_valid, dout(3)); end
        n_tests++; if (fifo_empty !== 4'b1000) begin n_fail++; $display("FAIL pop_empty3: got %b want 1000", fifo_empty); end
    endtask

    task automatic test_almost_full();
        do_reset_init(4'd6, 4'd2);
        for (int k = 0; k < 6; k++) begin
            push_word(12'h400 + 12'(k));
            if (k == 4) begin
                n_tests++; if (almost_full !== 4'b0000) begin n_fail++; $display("FAIL af_at5: got %b want 0000", almost_full); end
            end
        end
        n_tests++; if (almost_full !== 4'b0010 || pause !== 1'b1) begin
            n_fail++; $display("FAIL af_at6: af=%b pause=%b want 0010/1", almost_full, pause); end
        push_word(12'h406); push_word(12'h407);
        n_tests++; if (drop !== 1'b0 || error_out !== 1'b0) begin
            n_fail++; $display("FAIL full_nodrop: drop=%b err=%b want 0/0", drop, error_out); end
        push_word(12'h4FF);
        n_tests++; if (drop !== 1'b1 || error_out !== 1'b1) begin
            n_fail++; $display("FAIL drop_9th: drop=%b err=%b want 1/1", drop, error_out); end
        tick();
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %b want 0", drop); end
        req = 1'b1; idx = 3'd4; tick(); req = 1'b0;
        n_tests++; if (valid !== 1'b1 || data !== 8'd1) begin
            n_fail++; $display("FAIL drop_count: valid=%b data=%0d want 1/1", valid, data); end
        push_word(12'h0AA);     // ignored in ERROR
        n_tests++; if (fifo_empty[0] !== 1'b1) begin n_fail++; $display("FAIL err_push_ignored: empty0=%b want 1", fifo_empty[0]); end
        pop = 4'b0010; tick(); pop = '0;
        n_tests++; if (fifo_valid !== 4'b0010 || dout(1) !== 12'h400) begin
            n_fail++; $display("FAIL err_drain: valid=%b data=%h want 0010/400", fifo_valid, dout(1)); end
    endtask

    task automatic test_full_pushpop();
        do_reset_init(4'd6, 4'd2);
        for (int k = 0; k < 8; k++) push_word(12'h010 + 12'(k));
        push = 1'b1; data_in = 12'h0AA; pop = 4'b0001;
        tick();
        push = 1'b0; pop = '0;
        n_tests++; if (drop !== 1'b0 || error_out !== 1'b0) begin
            n_fail++; $display("FAIL full_pp_drop: drop=%b err=%b want 0/0", drop, error_out); end
        n_tests++; if (fifo_valid !== 4'b0001 || dout(0) !== 12'h010) begin
            n_fail++; $display("FAIL full_pp_data: valid=%b data=%h want 0001/010", fifo_valid, dout(0)); end
        pop = 4'b0001;
        for (int k = 0; k < 8; k++) tick();
        pop = '0;
        n_tests++; if (fifo_valid !== 4'b0001 || dout(0) !== 12'h0AA) begin
            n_fail++; $display("FAIL full_pp_last: valid=%b data=%h want 0001/0aa", fifo_valid, dout(0)); end
        n_tests++; if (fifo_empty[0] !== 1'b1) begin n_fail++; $display("FAIL full_pp_drained: got %b want 1", fifo_empty[0]); end
        tick();
        n_tests++; if (idle_out !== 1'b1) begin n_fail++; $display("FAIL back_to_idle: got %b want 1", idle_out); end
    endtask

    task automatic test_saturate();
        do_reset_init(4'd6, 4'd2);
        push_word(12'h801);
        push = 1'b1; pop = 4'b0100;
        for (int i = 0; i < 300; i++) begin
            data_in = {4'h8, 8'(i)};
            tick();
        end
        push = 1'b0; pop = '0;
        req = 1'b1; idx = 3'd2; clr_on_read = 1'b0; tick();
        n_tests++; if (valid !== 1'b1 || data !== 8'd255) begin
            n_fail++; $display("FAIL sat_read: valid=%b data=%0d want 1/255", valid, data); end
        clr_on_read = 1'b1; tick();
        n_tests++; if (valid !== 1'b1 || data !== 8'd255) begin
            n_fail++; $display("FAIL clr_read: valid=%b data=%0d want 1/255", valid, data); end
        clr_on_read = 1'b0; tick();
        n_tests++; if (valid !== 1'b1 || data !== 8'd0) begin
            n_fail++; $display("FAIL after_clr: valid=%b data=%0d want 1/0", valid, data); end
        pop = 4'b0100; clr_on_read = 1'b1; tick();
        pop = '0; clr_on_read = 1'b0;
        n_tests++; if (data !== 8'd0 || fifo_valid[2] !== 1'b1) begin
            n_fail++; $display("FAIL clr_inc_ret: data=%0d fv2=%b want 0/1", data, fifo_valid[2]); end
        tick();
        n_tests++; if (data !== 8'd1) begin n_fail++; $display("FAIL clr_inc_keep: got %0d want 1", data); end
        idx = 3'd5; tick(); req = 1'b0;
        n_tests++; if (valid !== 1'b1 || data !== 8'd0) begin
            n_fail++; $display("FAIL idx_oob: valid=%b data=%0d want 1/0", valid, data); end
        tick();
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b want 0", valid); end
    endtask

    task automatic test_pop_empty();
        pop = 4'b0001; tick(); pop = '0;
        n_tests++; if (fifo_valid !== 4'b0000) begin n_fail++; $display("FAIL pop_empty: got %b want 0000", fifo_valid); end
        req = 1'b1; idx = 3'd0; tick(); req = 1'b0;
        n_tests++; if (data !== 8'd0) begin n_fail++; $display("FAIL pop_empty_cnt: got %0d want 0", data); end
    endtask

    task automatic test_mid_reset();
        do_reset_init(4'd6, 4'd2);
        push_word(12'h401); push_word(12'h402); push_word(12'hC05);
        pop = 4'b0010; tick();
        reset = 1'b0; req = 1'b1; idx = 3'd1; push = 1'b1; data_in = 12'h403;
        tick();
        idle_inputs();
        n_tests++; if (fifo_valid !== 4'b0000 || valid !== 1'b0 || drop !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pulses: fv=%b valid=%b drop=%b want 0", fifo_valid, valid, drop); end
        n_tests++; if (fifo_empty !== 4'hF || almost_empty !== 4'hF || almost_full !== 4'h0 || pause !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: e=%h ae=%h af=%h p=%b want f/f/0/0", fifo_empty, almost_empty, almost_full, pause); end
        n_tests++; if (fifo_dataout !== '0 || data !== '0 || {idle_out, active_out, error_out} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_state: dout=%h data=%h st=%b want 0", fifo_dataout, data, {idle_out, active_out, error_out}); end
        reset = 1'b1; tick();   // -> INIT
        tick();                 // init=0 -> IDLE
        req = 1'b1; idx = 3'd1; tick(); req = 1'b0;
        n_tests++; if (valid !== 1'b1 || data !== 8'd0) begin
            n_fail++; $display("FAIL midrst_cnt: valid=%b data=%0d want 1/0", valid, data); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0; umbral_high = '0; umbral_low = '0;
        test_reset();
        test_classify();
        test_almost_full();
        test_full_pushpop();
        test_saturate();
        test_pop_empty();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qos_vc_param.md
# qos_vc_param

Parametrised QoS virtual-channel buffer for the PCIe path. It classifies each incoming word by its top bits into one of NUM_VC per-channel FIFOs and drains each FIFO under its own back-pressure pop. It raises programmable almost-full and almost-empty flags plus a global pause, and counts forwarded and dropped words in saturating, readable statistics counters. It sits between the transaction-layer source and the per-VC downstream consumers.

## Interface
- DATA_W, 12: word width; VC class is data_in[DATA_W-1 -: VC_W].
- NUM_VC, 4: channel count (≥2); VC_W = $clog2(NUM_VC).
- DEPTH, 8: words per FIFO, power of 2; AW = $clog2(DEPTH).
- CNT_W, 8: statistics counter width; IDX_W = $clog2(NUM_VC+1).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- init  in  1  configuration request; thresholds captured while in INIT.
- umbral_high  in  AW+1  almost-full threshold.
- umbral_low  in  AW+1  almost-empty threshold.
- push  in  1  write data_in to FIFO[class].
- data_in  in  DATA_W  incoming word.
- pop  in  NUM_VC  per-VC pop request.
- fifo_dataout  out  NUM_VC*DATA_W  popped word, VC i at [i*DATA_W +: DATA_W].
- fifo_valid  out  NUM_VC  popped word valid (1-cycle pulse).
- almost_full / almost_empty / fifo_empty  out  NUM_VC each  per-VC flags.
- pause  out  1  OR of almost_full.
- drop  out  1  pulse: push lost to a full FIFO.
- req  in  1  counter read request; idx  in  IDX_W  counter select; clr_on_read  in  1.
- valid  out  1  read data valid; data  out  CNT_W  counter value.
- active_out, idle_out, error_out  out  1  FSM state indicators.

## Operation
- Reset (reset=0 at an edge): state RESET. All FIFOs empty. Counters are 0. Thresholds are set to DEPTH-1 (high) and 1 (low). All outputs are 0 except fifo_empty and almost_empty, which are all-ones.
- FSM states: RESET, INIT, IDLE, ACTIVE, ERROR. Encoded one-hot.
  - RESET→INIT on the first edge with reset=1.
  - INIT: umbral_high and umbral_low are registered every cycle. INIT→IDLE when init=0.
  - IDLE: all FIFOs empty. IDLE→INIT if init=1. IDLE→ACTIVE on an accepted push.
  - ACTIVE: ACTIVE→IDLE when all FIFOs are empty and there is no push. init is ignored in ACTIVE.
  - ERROR: entered from IDLE or ACTIVE on a drop. Sticky until reset.
  - idle_out, active_out and error_out are decoded from the state register.
- Push is accepted only in IDLE or ACTIVE, otherwise ignored.
  - A push to a full FIFO without a simultaneous pop of that FIFO is a drop: the word is discarded, drop pulses next cycle, and the drop counter increments.
  - A push to a full FIFO with a simultaneous pop of that FIFO is accepted.
- Pop is served in IDLE, ACTIVE and ERROR. A pop on an empty FIFO is ignored: no valid pulse, no underflow.
  - Pushes are ignored in ERROR; pops continue there so the FIFOs drain.
- Each FIFO keeps an AW+1-bit occupancy count. A simultaneous push and pop on the same FIFO leaves the count unchanged. Pointers wrap modulo DEPTH.
- Flags are decoded from the registered count:
  - almost_full[i] = count ≥ umbral_high.
  - almost_empty[i] = count ≤ umbral_low.
  - fifo_empty[i] = count==0.
- Counters: NUM_VC forwarded-word counters, each incremented on every served pop, plus 1 drop counter. All saturate at 2^CNT_W-1 and never wrap.
- Read path:
  - req=1 at edge t gives valid=1 and data=counter[idx] at t+1.
  - idx==NUM_VC selects the drop counter; idx>NUM_VC returns 0.
  - With clr_on_read=1, the selected counter clears at edge t. An increment at the same edge leaves it at 1, and the returned value excludes that increment.

## Timing
- Push at edge t: count and flags update at t+1. The earliest pop is at edge t+1, and data plus fifo_valid appear after edge t+1.
- Pop-to-data latency is 1 cycle. fifo_dataout holds its last value when no pop is served.
- Read latency is 1 cycle. Back-to-back reqs give back-to-back valids.
- Reset asserted mid-operation: by the next edge all state returns to reset values and in-flight pops and reads are discarded.

## Structure
- qos_pkg holds the state enum and the default-threshold localparams.
- One sub-module, qos_fifo_sync (parametrised DATA_W/DEPTH with a count output), is instantiated NUM_VC times in a generate loop.
- The classifier, FSM, flag decode and statistics counters live in the top module.

## Test plan
- Reset then init=1 for 2 cycles with high=6, low=2, then init=0 → state IDLE; almost_empty=4'b1111 and pause=0.
- Push 0xC01, 0x402, 0x003, 0x804 → one word in each of VC3, VC1, VC0, VC2 and state ACTIVE. Pop VC3 → fifo_dataout VC3 = 0xC01 with fifo_valid[3]=1 one cycle later.
- Push 6 words to VC1 → almost_full[1]=1 and pause=1 after the 6th push. Push 3 more → the 9th drops, drop pulses, state goes ERROR, and a read at idx=4 returns 1.
- Fill VC0 to 8, then push and pop VC0 in the same cycle → no drop and count stays 8.
- Pop VC2 300 times (refilling between pops) → read idx=2 returns 255 (saturated). With clr_on_read=1 that read returns 255 and the next read returns 0.
- Pop an empty VC → no fifo_valid. Assert reset mid-traffic → all flags and counters return to reset values.
